// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions: ALU operation encodings plus the
// multiply/divide unit state type and helpers.
package riscv_defines;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alucontrol_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

  localparam int MULDIV_DIV_CYCLES = 32;
  localparam int MULDIV_CNT_W      = $clog2(MULDIV_DIV_CYCLES);

  function automatic logic is_m_op(input alucontrol_t op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div_op(input alucontrol_t op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input alucontrol_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_quotient_op(input alucontrol_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per
// step, counter runs from MULDIV_DIV_CYCLES-1 down to 0.
module muldiv_div_core
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  logic [XLEN-1:0]         rem_q;
  logic [XLEN-1:0]         quo_q;
  logic [XLEN-1:0]         dsr_q;
  logic [MULDIV_CNT_W-1:0] cnt_q;
  logic [XLEN:0]           partial;
  logic [XLEN:0]           diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // diff[XLEN] set means the divisor did not fit.
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign diff    = partial - {1'b0, dsr_q};

  // NOTE: every sequential register uses non-blocking (<=) so all flops
  // update together at the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= MULDIV_CNT_W'(MULDIV_DIV_CYCLES - 1);
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= partial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage unit: single-cycle multiply and divide special cases
// via CALC, iterative divide via DIV/FIX, registered result with done pulse.
module muldiv_unit
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alucontrol_t     alucontrol,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t   state;
  alucontrol_t     op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  logic            accept;
  logic            special_in;
  logic            sgn_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_load;
  logic            div_step;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            div_last;

  assign accept = start && !flush && ((state == IDLE) || (state == DONE))
                  && is_m_op(alucontrol);

  assign sgn_in     = is_signed_div(alucontrol);
  assign special_in = (operand_b == '0) ||
                      (sgn_in && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                              && (operand_b == '1));

  assign mag_a = (sgn_in && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign mag_b = (sgn_in && operand_b[XLEN-1]) ? -operand_b : operand_b;

  assign div_load = accept && is_div_op(alucontrol) && !special_in;
  assign div_step = (state == DIV) && !flush;

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  logic signed [XLEN:0]     mul_a;
  logic signed [XLEN:0]     mul_b;
  logic signed [2*XLEN+1:0] product;
  logic [XLEN-1:0]          calc_result;
  logic [XLEN-1:0]          fix_result;
  logic                     sgn_q;

  assign sgn_q = is_signed_div(op_q);
  assign mul_a = {(op_q != ALU_MULHU) & a_q[XLEN-1], a_q};
  assign mul_b = {((op_q == ALU_MUL) || (op_q == ALU_MULH)) & b_q[XLEN-1], b_q};
  assign product = mul_a * mul_b;

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    calc_result = product[2*XLEN-1:XLEN];
    if (op_q == ALU_MUL) begin
      calc_result = product[XLEN-1:0];
    end else if (is_div_op(op_q)) begin
      if (b_q == '0) calc_result = is_quotient_op(op_q) ? '1 : a_q;
      else           calc_result = is_quotient_op(op_q) ? a_q : '0;
    end
  end

  always_comb begin
    fix_result = div_rem;
    if (is_quotient_op(op_q)) begin
      fix_result = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quo : div_quo;
    end else if (sgn_q && a_q[XLEN-1]) begin
      fix_result = -div_rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= ALU_ADD;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (accept) begin
            op_q  <= alucontrol;
            a_q   <= operand_a;
            b_q   <= operand_b;
            busy  <= 1'b1;
            state <= div_load ? DIV : CALC;
          end
        end
        CALC: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            result <= calc_result;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (div_last) begin
            state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            result <= fix_result;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of operations with expected
// result and latency, plus flush/reset/handshake sequences.
module tb_muldiv_unit;
  import riscv_defines::*;

  localparam int LIMIT = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  alucontrol_t alucontrol = ALU_ADD;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alucontrol (alucontrol),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  typedef struct {
    string       name;
    alucontrol_t op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Issue one request and wait for done; returns at the negedge of the done
  // cycle. lat is the cycle index (acceptance edge = 0), or -1 on timeout.
  task automatic run_op(input alucontrol_t op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic busy1);
    @(negedge clk);
    alucontrol = op; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    if (!done) lat = -1;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        b1;
    logic [31:0] prev;
    logic        saw;

    vecs[0]  = '{"mul_7_m3",     ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2};
    vecs[1]  = '{"mulhu_m1",     ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
    vecs[2]  = '{"mulh_m1",      ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[3]  = '{"mulhsu_m1",    ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[4]  = '{"mulhu_2p31x2", ALU_MULHU,  32'h80000000, 32'd2,        32'h00000001, 2};
    vecs[5]  = '{"div_m7_2",     ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[6]  = '{"rem_m7_2",     ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[7]  = '{"divu_100_7",   ALU_DIVU,   32'd100,      32'd7,        32'd14,       34};
    vecs[8]  = '{"remu_100_7",   ALU_REMU,   32'd100,      32'd7,        32'd2,        34};
    vecs[9]  = '{"div_7_m2",     ALU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[10] = '{"rem_7_m2",     ALU_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};
    vecs[11] = '{"divu_3_7",     ALU_DIVU,   32'd3,        32'd7,        32'd0,        34};
    vecs[12] = '{"div_5_0",      ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vecs[13] = '{"remu_5_0",     ALU_REMU,   32'd5,        32'd0,        32'd5,        2};
    vecs[14] = '{"div_ovf",      ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[15] = '{"rem_ovf",      ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2};

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, b1);
      check({vecs[i].name, "_result"}, res, vecs[i].expv);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_busy_c1"}, 32'(b1), 32'd1);
      check({vecs[i].name, "_busy_at_done"}, 32'(busy), 32'd0);
    end

    // Back-to-back: a MUL issued during DONE completes two cycles later.
    start = 1'b1; alucontrol = ALU_MUL; operand_a = 32'd2; operand_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_c1", 32'(busy), 32'd1);
    check("b2b_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    check("b2b_done_c2", 32'(done), 32'd1);
    check("b2b_result", result, 32'd4);

    // Flush at cycle 10 of a divide.
    prev = result;
    @(negedge clk);
    alucontrol = ALU_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result_held", result, prev);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw |= done;
    end
    check("flush_no_done", 32'(saw), 32'd0);

    run_op(ALU_MUL, 32'd3, 32'd4, lat, res, b1);
    check("mul_after_flush_result", res, 32'd12);
    check("mul_after_flush_latency", 32'(lat), 32'd2);

    // Start while busy is ignored: the divide finishes with its own result.
    @(negedge clk);
    alucontrol = ALU_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    alucontrol = ALU_MUL; operand_a = 32'd2; operand_b = 32'd2; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    check("busy_start_ignored_result", result, 32'd14);
    check("busy_start_ignored_latency", 32'(lat), 32'd34);

    // Flush together with start in IDLE drops the request.
    @(negedge clk);
    alucontrol = ALU_MUL; operand_a = 32'd5; operand_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    saw = busy;
    repeat (3) begin
      @(negedge clk);
      saw |= busy | done;
    end
    check("flush_start_dropped", 32'(saw), 32'd0);

    // Non-M operation is ignored and result is held.
    @(negedge clk);
    alucontrol = ALU_ADD; operand_a = 32'd1; operand_b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw = busy | done;
    repeat (3) begin
      @(negedge clk);
      saw |= busy | done;
    end
    check("alu_add_ignored", 32'(saw), 32'd0);
    check("alu_add_result_held", result, 32'd14);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    alucontrol = ALU_DIV; operand_a = 32'hFFFFFFF9; operand_b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= done | busy;
    end
    check("rst_mid_no_done", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle execution unit for the RV32M operations (`ALU_MUL` … `ALU_REMU`) selected by the ALU decoder's `alucontrol_t` output.
- Sits in the execute stage beside the single-cycle ALU.
- Accepts one operation per start handshake and returns a registered 32-bit result with a one-cycle `done` pulse.
- The hazard unit uses `busy` to stall the pipeline.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; accepted only in IDLE or DONE
- `alucontrol`  in  alucontrol_t  operation; sampled with `start`
- `operand_a`  in  XLEN  rs1 value; sampled with `start`
- `operand_b`  in  XLEN  rs2 value; sampled with `start`
- `flush`  in  1  abort the in-flight operation
- `busy`  out  1  high in CALC, DIV and FIX states
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  XLEN  last completed result; held until the next completion

## Operation
- States: IDLE, CALC, DIV, FIX, DONE.
- **Accepting a request.** `start` is accepted in IDLE or DONE. `start` is ignored while `busy=1`.
- **Non-M operations.** `start` with an `alucontrol` outside `ALU_MUL..ALU_REMU` is ignored; the state is unchanged.
- **MUL/MULH/MULHSU/MULHU.** Go IDLE→CALC→DONE.
  - Form 33×33 signed product: sign-extend a for MUL/MULH/MULHSU; sign-extend b for MUL/MULH only.
  - MUL returns bits [31:0]; the others return [63:32].
- **DIV/DIVU/REM/REMU, special cases.** These go via CALC (2-cycle path):
  - b=0: quotient = 0xFFFFFFFF; remainder = a.
  - Signed a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **DIV/DIVU/REM/REMU, general case.** Go IDLE→DIV→FIX→DONE.
  - Signed ops divide magnitudes.
  - DIV: radix-2 restoring, one quotient bit per cycle, 5-bit counter from 31 down to 0.
  - FIX: negate the quotient if the signs of a and b differ; negate the remainder if a<0; select quotient or remainder.
- **DONE.** Lasts one cycle with `done=1`. Returns to IDLE unless a new `start` is accepted.
- **flush.**
  - In CALC, DIV or FIX: next state is IDLE, no `done`, `result` unchanged.
  - In IDLE or DONE: has no effect on state.
  - Asserted together with `start`: `flush` wins and the request is dropped.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, internal operand/remainder registers=0.
- Start accepted at edge 0:
  - Multiply and divide special cases: `done` high in cycle 2.
  - General divide: `done` high in cycle 34 (32 DIV cycles + FIX).
- `busy` rises in the cycle after acceptance and falls in the DONE cycle.
- **Back-to-back.** `start` during DONE is accepted; the next operation's CALC/DIV starts the following cycle. No idle bubble is required.
- **Result timing.** `result` and `done` are both registered and change in the same cycle.
- **Reset mid-operation.** Asynchronously returns to the reset values; no `done` is produced.

## Structure
- Add to `riscv_defines`:
  - `muldiv_state_t` enum: IDLE, CALC, DIV, FIX, DONE.
  - `MULDIV_DIV_CYCLES` = 32.
- Reuse the existing `alucontrol_t` encodings; no new ALU encodings.
- Sub-module `muldiv_div_core`:
  - Owns the iterative restoring-divide datapath: remainder/quotient shift registers, counter, subtract-compare.
  - Interface: load, step enable, quotient, remainder, last-step flag.
- The top level holds the FSM, multiply, special-case detection and sign fix-up.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB, `done` in cycle 2, `busy` high in cycle 1 only.
- a=b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
- Division, `done` in cycle 34 each:
  - DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD
  - REM → 0xFFFFFFFF
  - DIVU 100/7 → 14
  - REMU 100/7 → 2
- Special cases, 2-cycle latency:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
- Flush and reset:
  - `flush` in cycle 10 of DIV → no `done`, `busy`=0 next cycle, `result` keeps its prior value.
  - A following MUL 3×4 → 12 in cycle 2.
  - `rst_n` low mid-DIV → all outputs 0, no `done`.
- Handshake and ignored requests:
  - `start` while busy is ignored.
  - `start` (MUL 2×2) in a DONE cycle is accepted → `done` two cycles later with 4.
  - `start` with `ALU_ADD` → no `busy`, no `done`.
